drive_pwm_ctrl: RTL and testbench

Parametrised multi-channel H-bridge drive controller. It replaces per-speed free-running PWM counters with one shared period counter and per-channel programmable duty. It adds slew-limited duty ramping, safe direction reversal through zero, and a latched collision brake with timed release. It sits between the steering/tone-decision logic, which issues duty/direction commands, and the H-bridge enable/input pins.

---
 rtl/drive_pkg.sv | 27 ++
 rtl/drive_pwm_ctrl_if.sv | 12 +
 rtl/pwm_ramp_ch.sv | 76 +++++++
 rtl/drive_pwm_ctrl.sv | 100 ++++++++++
 tb/tb_drive_pwm_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/drive_pkg.sv
// drive_pkg: shared direction/state encodings and PWM period derivations
// for the multi-channel H-bridge drive controller.
package drive_pkg;

    localparam logic [1:0] DIR_COAST = 2'b00;
    localparam logic [1:0] DIR_FWD   = 2'b01;
    localparam logic [1:0] DIR_REV   = 2'b10;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    localparam logic [1:0] ST_RUN = 2'b00;
    localparam logic [1:0] ST_COL = 2'b01;
    localparam logic [1:0] ST_CLR = 2'b10;

    localparam int DUTY_W = 7;

    typedef logic [DUTY_W-1:0] duty_t;
    typedef logic [1:0]        dir_t;

    function automatic int calc_period(input int clk_hz, input int pwm_hz);
        return clk_hz / pwm_hz;
    endfunction

    function automatic int calc_pct(input int period);
        return period / 100;
    endfunction

endpackage

// File: rtl/drive_pwm_ctrl_if.sv
// drive_pwm_ctrl_if: duty/direction command handshake from the steering logic.
interface drive_pwm_ctrl_if #(
    parameter int NUM_CH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [NUM_CH*7-1:0] cmd_duty;
    logic [NUM_CH*2-1:0] cmd_dir;

    modport master (output cmd_valid, cmd_duty, cmd_dir, input cmd_ready);
    modport slave  (input cmd_valid, cmd_duty, cmd_dir, output cmd_ready);
endinterface

// File: rtl/pwm_ramp_ch.sv
// pwm_ramp_ch: one bridge channel - target/current duty and direction, slew ramp and PWM compare.
// Pins are registered from the post-update duty so a new duty applies from the first clock of its period.
module pwm_ramp_ch
    import drive_pkg::*;
#(
    parameter int PCT_CNT   = 1,
    parameter int MAX_DUTY  = 80,
    parameter int RAMP_STEP = 5,
    parameter int PW        = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ps_i,
    input  logic          kill_i,
    input  logic          load_i,
    input  duty_t         duty_i,
    input  dir_t          dir_i,
    input  logic [PW-1:0] pcnt_i,
    output logic          hb_en_o,
    output logic          hb_a_o,
    output logic          hb_b_o
);
    localparam duty_t MAX_D = duty_t'(MAX_DUTY);
    localparam duty_t STEP  = duty_t'(RAMP_STEP);

    duty_t tgt_duty_q, tgt_duty_d, cur_duty_q, cur_duty_d;
    dir_t  tgt_dir_q, tgt_dir_d, cur_dir_q, cur_dir_d;
    logic  on, en_d, a_d, b_d;

    always_comb begin
        tgt_duty_d = load_i ? (duty_i > MAX_D ? MAX_D : duty_i) : tgt_duty_q;
        tgt_dir_d  = load_i ? dir_i : tgt_dir_q;
        cur_duty_d = cur_duty_q;
        cur_dir_d  = cur_dir_q;
        if (ps_i) begin
            // a reversal first ramps to zero, then spends one dead period at zero while the direction flips
            if (tgt_dir_q != cur_dir_q) begin
                cur_duty_d = cur_duty_q > STEP ? cur_duty_q - STEP : '0;
                cur_dir_d  = cur_duty_q == '0 ? tgt_dir_q : cur_dir_q;
            end else if (cur_duty_q < tgt_duty_q)
                cur_duty_d = tgt_duty_q - cur_duty_q > STEP ? cur_duty_q + STEP : tgt_duty_q;
            else
                cur_duty_d = cur_duty_q - tgt_duty_q > STEP ? cur_duty_q - STEP : tgt_duty_q;
        end
        if (kill_i) begin
            tgt_duty_d = '0;
            tgt_dir_d  = DIR_COAST;
            cur_duty_d = '0;
            cur_dir_d  = DIR_COAST;
        end
        on   = 32'(pcnt_i) < 32'(cur_duty_d) * PCT_CNT;
        en_d = !kill_i && (cur_dir_d == DIR_BRAKE || (cur_dir_d != DIR_COAST && on));
        a_d  = kill_i || cur_dir_d == DIR_REV || cur_dir_d == DIR_BRAKE;
        b_d  = kill_i || cur_dir_d == DIR_FWD || cur_dir_d == DIR_BRAKE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tgt_duty_q <= '0;
            tgt_dir_q  <= DIR_COAST;
            cur_duty_q <= '0;
            cur_dir_q  <= DIR_COAST;
            hb_en_o    <= 1'b0;
            hb_a_o     <= 1'b0;
            hb_b_o     <= 1'b0;
        end else begin
            tgt_duty_q <= tgt_duty_d;
            tgt_dir_q  <= tgt_dir_d;
            cur_duty_q <= cur_duty_d;
            cur_dir_q  <= cur_dir_d;
            hb_en_o    <= en_d;
            hb_a_o     <= a_d;
            hb_b_o     <= b_d;
        end

endmodule

// File: rtl/drive_pwm_ctrl.sv
// drive_pwm_ctrl: shared PWM period counter, collision synchroniser/state machine and command
// handshake feeding NUM_CH slew-limited H-bridge channels.
module drive_pwm_ctrl
    import drive_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int PWM_HZ        = 80,
    parameter int NUM_CH        = 2,
    parameter int MAX_DUTY      = 80,
    parameter int RAMP_STEP     = 5,
    parameter int CLEAR_PERIODS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    drive_pwm_ctrl_if.slave     cmd,
    input  logic                col_n,
    input  logic                estop,
    output logic [NUM_CH-1:0]   hb_en,
    output logic [NUM_CH-1:0]   hb_in_a,
    output logic [NUM_CH-1:0]   hb_in_b,
    output logic [1:0]          state,
    output logic                period_start
);
    localparam int PERIOD  = calc_period(CLK_HZ, PWM_HZ);
    localparam int PCT_CNT = calc_pct(PERIOD);
    localparam int PW      = PERIOD > 1 ? $clog2(PERIOD) : 1;
    localparam int CW      = $clog2(CLEAR_PERIODS + 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    st_q, st_d;
    logic          sync1_q, sync2_q, ps_q, rdy_q;
    logic          ps, col, kill, load;

    assign ps            = pcnt_q == '0;
    assign pcnt_d        = pcnt_q == PW'(PERIOD - 1) ? '0 : pcnt_q + PW'(1);
    assign col           = !sync2_q || estop;
    assign kill          = col || st_q != ST_RUN;
    // a command landing in the same cycle as a collision is dropped
    assign load          = cmd.cmd_valid && rdy_q && !col;
    assign cmd.cmd_ready = rdy_q;
    assign state         = st_q;
    assign period_start  = ps_q;

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        if (col) begin
            st_d  = ST_COL;
            cnt_d = '0;
        end else if (st_q == ST_COL) begin
            st_d  = ST_CLR;
            cnt_d = '0;
        end else if (st_q == ST_CLR && ps) begin
            st_d  = cnt_q == CW'(CLEAR_PERIODS - 1) ? ST_RUN : ST_CLR;
            cnt_d = cnt_q == CW'(CLEAR_PERIODS - 1) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pcnt_q  <= '0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            st_q    <= ST_RUN;
            cnt_q   <= '0;
            ps_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            sync1_q <= col_n;
            sync2_q <= sync1_q;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            ps_q    <= ps;
            rdy_q   <= st_d == ST_RUN;
        end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_ramp_ch #(
            .PCT_CNT  (PCT_CNT),
            .MAX_DUTY (MAX_DUTY),
            .RAMP_STEP(RAMP_STEP),
            .PW       (PW)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .ps_i   (ps),
            .kill_i (kill),
            .load_i (load),
            .duty_i (cmd.cmd_duty[i*DUTY_W +: DUTY_W]),
            .dir_i  (cmd.cmd_dir[i*2 +: 2]),
            .pcnt_i (pcnt_q),
            .hb_en_o(hb_en[i]),
            .hb_a_o (hb_in_a[i]),
            .hb_b_o (hb_in_b[i])
        );
    end

endmodule

// File: tb/tb_drive_pwm_ctrl.sv
// tb_drive_pwm_ctrl: random commands against a per-period duty model; a monitor scores each
// PWM period (high-time count and direction pins) and directed checks cover collision/reset.
module tb_drive_pwm_ctrl;
    localparam int NCH    = 2;
    localparam int PERIOD = 100;
    localparam int STEP   = 5;
    localparam int MAXD   = 80;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           col_n = 1'b1;
    logic           estop = 1'b0;
    logic [NCH-1:0] hb_en, hb_in_a, hb_in_b;
    logic [1:0]     state;
    logic           period_start;

    drive_pwm_ctrl_if #(.NUM_CH(NCH)) cmd ();

    drive_pwm_ctrl #(
        .CLK_HZ(10_000),
        .PWM_HZ(100),
        .NUM_CH(NCH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd),
        .col_n       (col_n),
        .estop       (estop),
        .hb_en       (hb_en),
        .hb_in_a     (hb_in_a),
        .hb_in_b     (hb_in_b),
        .state       (state),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0][7:0] en;
        logic [NCH-1:0]      a;
        logic [NCH-1:0]      b;
    } exp_t;

    exp_t           sb_q[$];
    int             n_chk = 0, n_pass = 0;
    bit             mon_en = 0;
    int             m_tgt_d[NCH], m_tgt_r[NCH], m_cur_d[NCH], m_cur_r[NCH];
    int             mon_cnt[NCH];
    logic [NCH-1:0] mon_a, mon_b;
    bit             mon_have = 0, mon_unstable = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            m_tgt_d[c] = 0; m_tgt_r[c] = 0; m_cur_d[c] = 0; m_cur_r[c] = 0;
        end
    endtask

    // advance the model by one PWM period and queue what the pins should show over it
    task automatic model_step();
        exp_t e;
        e = '0;
        for (int c = 0; c < NCH; c++) begin
            if (m_tgt_r[c] != m_cur_r[c]) begin
                if (m_cur_d[c] > 0) m_cur_d[c] = m_cur_d[c] > STEP ? m_cur_d[c] - STEP : 0;
                else m_cur_r[c] = m_tgt_r[c];
            end else if (m_cur_d[c] < m_tgt_d[c])
                m_cur_d[c] = (m_cur_d[c] + STEP < m_tgt_d[c]) ? m_cur_d[c] + STEP : m_tgt_d[c];
            else
                m_cur_d[c] = (m_cur_d[c] - STEP > m_tgt_d[c]) ? m_cur_d[c] - STEP : m_tgt_d[c];
            case (m_cur_r[c])
                0: begin e.en[c] = 0; e.a[c] = 0; e.b[c] = 0; end
                1: begin e.en[c] = 8'(m_cur_d[c]); e.a[c] = 0; e.b[c] = 1; end
                2: begin e.en[c] = 8'(m_cur_d[c]); e.a[c] = 1; e.b[c] = 0; end
                default: begin e.en[c] = 8'(PERIOD); e.a[c] = 1; e.b[c] = 1; end
            endcase
        end
        sb_q.push_back(e);
    endtask

    task automatic resync();
        sb_q.delete();
        model_step();
        mon_en = 1;
    endtask

    task automatic wait_ps();
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            if (period_start) return;
        end
        chk("period_start_timeout", 0, 1);
    endtask

    task automatic wait_state(input logic [1:0] s, input int limit, input string nm);
        for (int i = 0; i < limit && state != s; i++) @(negedge clk);
        chk(nm, int'(state), int'(s));
    endtask

    task automatic send_cmd(input int d0, input int r0, input int d1, input int r1);
        @(negedge clk);
        chk("cmd_ready_run", int'(cmd.cmd_ready), 1);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_duty  = {7'(d1), 7'(d0)};
        cmd.cmd_dir   = {2'(r1), 2'(r0)};
        @(negedge clk);
        cmd.cmd_valid = 1'b0;
        m_tgt_d[0] = d0 > MAXD ? MAXD : d0; m_tgt_r[0] = r0;
        m_tgt_d[1] = d1 > MAXD ? MAXD : d1; m_tgt_r[1] = r1;
    endtask

    task automatic run_period(input bit do_cmd, input int d0, input int r0, input int d1, input int r1);
        wait_ps();
        repeat (40) @(negedge clk);
        if (do_cmd) send_cmd(d0, r0, d1, r1);
        model_step();
    endtask

    // monitor: one comparison set per completed PWM period
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) mon_have = 0;
            else begin
                if (period_start) begin
                    if (mon_have) begin
                        if (sb_q.size() == 0) chk("sb_underflow", 0, 1);
                        else begin
                            exp_t e;
                            e = sb_q.pop_front();
                            for (int c = 0; c < NCH; c++) begin
                                chk($sformatf("en_cnt_ch%0d", c), mon_cnt[c], int'(e.en[c]));
                                chk($sformatf("in_a_ch%0d", c), int'(mon_a[c]), int'(e.a[c]));
                                chk($sformatf("in_b_ch%0d", c), int'(mon_b[c]), int'(e.b[c]));
                            end
                            chk("dir_pins_stable", int'(mon_unstable), 0);
                        end
                    end
                    mon_have = 1;
                    mon_unstable = 0;
                    mon_a = hb_in_a;
                    mon_b = hb_in_b;
                    for (int c = 0; c < NCH; c++) mon_cnt[c] = 0;
                end
                if (mon_have) begin
                    for (int c = 0; c < NCH; c++) mon_cnt[c] += int'(hb_en[c]);
                    if (hb_in_a != mon_a || hb_in_b != mon_b) mon_unstable = 1;
                end
            end
        end
    end

    initial begin
        cmd.cmd_valid = 1'b0;
        cmd.cmd_duty  = '0;
        cmd.cmd_dir   = '0;
        repeat (3) @(negedge clk);
        chk("rst_hb_en", int'(hb_en), 0);
        chk("rst_in_a", int'(hb_in_a), 0);
        chk("rst_in_b", int'(hb_in_b), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_period_start", int'(period_start), 0);
        chk("rst_cmd_ready", int'(cmd.cmd_ready), 0);
        model_clear();
        resync();
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", int'(cmd.cmd_ready), 1);
        chk("first_period_start", int'(period_start), 1);

        run_period(0, 0, 0, 0, 0);
        run_period(1, 50, 1, 0, 0);
        repeat (12) run_period(0, 0, 0, 0, 0);
        run_period(1, 100, 1, 20, 2);
        repeat (18) run_period(0, 0, 0, 0, 0);
        run_period(1, 30, 1, 20, 2);
        repeat (12) run_period(0, 0, 0, 0, 0);
        run_period(1, 30, 2, 20, 2);
        repeat (14) run_period(0, 0, 0, 0, 0);
        for (int k = 0; k < 25; k++)
            run_period($urandom_range(0, 1) == 1, int'($urandom_range(0, 127)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 127)), int'($urandom_range(0, 3)));

        // collision during a live period, then a re-glitch while clearing
        wait_ps();
        mon_en = 0;
        repeat (30) @(negedge clk);
        col_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("col_state", int'(state), 1);
        chk("col_hb_en", int'(hb_en), 0);
        chk("col_in_a", int'(hb_in_a), 3);
        chk("col_in_b", int'(hb_in_b), 3);
        chk("col_cmd_ready", int'(cmd.cmd_ready), 0);
        repeat (20) @(negedge clk);
        col_n = 1'b1;
        wait_state(2'b10, 20, "enter_clear");
        for (int k = 0; k < 2; k++) begin
            wait_ps();
            chk("clear_hold", int'(state), 2);
        end
        repeat (30) @(negedge clk);
        col_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("reglitch_state", int'(state), 1);
        col_n = 1'b1;
        wait_state(2'b10, 20, "reenter_clear");
        for (int k = 1; k <= 4; k++) begin
            wait_ps();
            chk($sformatf("clear_pulse%0d", k), int'(state), k < 4 ? 2 : 0);
        end
        chk("run_cmd_ready", int'(cmd.cmd_ready), 1);
        @(negedge clk);
        chk("run_hb_en", int'(hb_en), 0);
        chk("run_in_a", int'(hb_in_a), 0);
        chk("run_in_b", int'(hb_in_b), 0);
        model_clear();
        resync();
        run_period(1, 40, 2, 60, 1);
        repeat (6) run_period(0, 0, 0, 0, 0);

        // estop acts without the synchroniser
        mon_en = 0;
        @(negedge clk);
        estop = 1'b1;
        @(negedge clk);
        chk("estop_state", int'(state), 1);
        chk("estop_hb_en", int'(hb_en), 0);
        estop = 1'b0;
        wait_state(2'b10, 5, "estop_clear");
        wait_state(2'b00, 6 * PERIOD, "estop_run");
        @(negedge clk);
        model_clear();
        resync();

        // asynchronous reset mid-ramp at duty 25
        run_period(1, 50, 1, 0, 0);
        repeat (4) run_period(0, 0, 0, 0, 0);
        wait_ps();
        repeat (10) @(negedge clk);
        chk("pre_rst_en", int'(hb_en[0]), 1);
        mon_en = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hb_en", int'(hb_en), 0);
        chk("arst_in_a", int'(hb_in_a), 0);
        chk("arst_in_b", int'(hb_in_b), 0);
        chk("arst_state", int'(state), 0);
        chk("arst_cmd_ready", int'(cmd.cmd_ready), 0);
        repeat (3) @(negedge clk);
        model_clear();
        resync();
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_arst", int'(cmd.cmd_ready), 1);
        repeat (4) run_period(0, 0, 0, 0, 0);
        wait_ps();
        wait_ps();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
